// File: rtl/mc_sequencer.sv
// Multi-cycle controller sequencer: fetch/decode/execute FSM driving datapath controls.
// Optional feature: define MC_SEQ_PERF_EN to enable the retired-instruction counter;
// without it the retired port reads constant zero and no counter flops are built.
module mc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  state,
    output logic        illegal,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StLwWb     = 4'd4,
        StMemWrite = 4'd5,
        StExec     = 4'd6,
        StRwb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StTrap     = 4'd10
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e     r_state;
    state_e     w_next;
    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;

    // State register; reset aborts any in-flight instruction back to fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state control outputs.
    always_comb begin
        w_next          = StTrap;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        IorD            = 1'b0;
        MemtoReg        = 1'b0;
        ALUSrcA         = 1'b0;
        RegDst          = 1'b0;
        PCSource        = 2'b00;
        ALUOp           = 2'b00;
        ALUSrcB         = 2'b00;
        illegal         = 1'b0;
        case (r_state)
            StFetch: begin
                w_mem_read = 1'b1;
                ALUSrcB    = 2'b01;
                // IR and PC only update on the cycle memory delivers the word.
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
                w_next     = mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                ALUSrcB = 2'b11;
                case (op)
                    OpRtype:    w_next = StExec;
                    OpLw, OpSw: w_next = StMemAddr;
                    OpBeq:      w_next = StBranch;
                    OpJ:        w_next = StJump;
                    default:    w_next = StTrap;
                endcase
            end
            StMemAddr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (op)
                    OpLw:    w_next = StMemRead;
                    OpSw:    w_next = StMemWrite;
                    default: w_next = StTrap;
                endcase
            end
            StMemRead: begin
                w_mem_read = 1'b1;
                IorD       = 1'b1;
                w_next     = mem_ready ? StLwWb : StMemRead;
            end
            StLwWb: begin
                w_reg_write = 1'b1;
                MemtoReg    = 1'b1;
                w_next      = StFetch;
            end
            StMemWrite: begin
                w_mem_write = 1'b1;
                IorD        = 1'b1;
                w_next      = mem_ready ? StFetch : StMemWrite;
            end
            StExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = StRwb;
            end
            StRwb: begin
                RegDst      = 1'b1;
                w_reg_write = 1'b1;
                w_next      = StFetch;
            end
            StBranch: begin
                ALUSrcA         = 1'b1;
                ALUOp           = 2'b01;
                w_pc_write_cond = 1'b1;
                PCSource        = 2'b01;
                w_next          = StFetch;
            end
            StJump: begin
                w_pc_write = 1'b1;
                PCSource   = 2'b10;
                w_next     = StFetch;
            end
            StTrap: begin
                illegal = 1'b1;
                w_next  = StTrap;
            end
            // Unused codes fall into the trap on the next edge.
            default: w_next = StTrap;
        endcase
    end

    // Write/read enables are held off for the whole reset assertion.
    assign PCWrite     = w_pc_write & ~reset;
    assign PCWriteCond = w_pc_write_cond & ~reset;
    assign MemRead     = w_mem_read & ~reset;
    assign MemWrite    = w_mem_write & ~reset;
    assign IRWrite     = w_ir_write & ~reset;
    assign RegWrite    = w_reg_write & ~reset;
    assign state       = r_state;

`ifdef MC_SEQ_PERF_EN
    logic [31:0] r_retired;
    logic        w_retire;

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            StLwWb, StRwb, StBranch, StJump: w_retire = 1'b1;
            StMemWrite:                      w_retire = mem_ready;
            default:                         w_retire = 1'b0;
        endcase
    end

    // Free-running retired counter, wraps modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = 32'd0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: instruction-path model plus directed vectors.
module tb_mc_sequencer;

    localparam logic [5:0] OpR   = 6'b000000;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpSw  = 6'b101011;
    localparam logic [5:0] OpBeq = 6'b000100;
    localparam logic [5:0] OpJ   = 6'b000010;
    localparam logic [5:0] OpBad = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic [3:0]  state;
    logic        illegal;
    logic [31:0] retired;

    int n_vec = 0;
    int n_err = 0;

    mc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .state       (state),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- Instruction-path model ----------------
    // Each instruction class is a list of states visited after decode;
    // memory states (3, 5) repeat until mem_ready.
    // Classes: 0 R, 1 lw, 2 sw, 3 beq, 4 j.
    int paths [5][3] = '{'{6, 7, 0}, '{2, 3, 4}, '{2, 5, 0}, '{8, 0, 0}, '{9, 0, 0}};
    int lens  [5]    = '{2, 3, 2, 1, 1};

    int          m_phase;   // 0 fetch, 1 decode, 2 walking a path, 3 trapped
    int          m_cls;
    int          m_pos;
    logic [31:0] m_ret;

    function automatic int exp_state(input int ph, input int cls, input int pos);
        if (ph == 0) return 0;
        if (ph == 1) return 1;
        if (ph == 3) return 10;
        return paths[cls][pos];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_cls   <= 0;
            m_pos   <= 0;
            m_ret   <= 32'd0;
        end else begin
            case (m_phase)
                0: if (mem_ready) m_phase <= 1;
                1: begin
                    m_pos   <= 0;
                    m_phase <= 2;
                    if (op == OpR) m_cls <= 0;
                    else if (op == OpLw || op == OpSw) m_cls <= 1;
                    else if (op == OpBeq) m_cls <= 3;
                    else if (op == OpJ) m_cls <= 4;
                    else m_phase <= 3;
                end
                2: begin
                    if (paths[m_cls][m_pos] == 2) begin
                        m_pos <= 1;
                        if (op == OpLw) m_cls <= 1;
                        else if (op == OpSw) m_cls <= 2;
                        else m_phase <= 3;
                    end else if ((paths[m_cls][m_pos] == 3 || paths[m_cls][m_pos] == 5)
                                 && !mem_ready) begin
                        m_pos <= m_pos;
                    end else if (m_pos + 1 < lens[m_cls]) begin
                        m_pos <= m_pos + 1;
                    end else begin
                        m_phase <= 0;
                        m_ret   <= m_ret + 32'd1;
                    end
                end
                default: m_phase <= 3;
            endcase
        end
    end

    // Expected control word for a state: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
    // IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, illegal}.
    function automatic logic [16:0] exp_ctrl(input int s, input logic mr, input logic rst);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, ill;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, ill} = '0;
        {pcs, aop, asb} = '0;
        case (s)
            0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin mrd = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin mwr = 1'b1; iord = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            9:  begin pcw = 1'b1; pcs = 2'b10; end
            10: ill = 1'b1;
            default: ;
        endcase
        if (rst) {pcw, pcwc, irw, mrd, mwr, rw} = '0;
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, aop, asb, ill};
    endfunction

    logic [16:0] w_act;
    assign w_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, illegal};

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("state", {28'd0, state}, exp_state(m_phase, m_cls, m_pos));
        chk("ctrl", {15'd0, w_act},
            {15'd0, exp_ctrl(exp_state(m_phase, m_cls, m_pos), mem_ready, reset)});
`ifdef MC_SEQ_PERF_EN
        chk("retired", retired, m_ret);
`else
        chk("retired", retired, 32'd0);
`endif
    end

    // ---------------- Directed stimulus ----------------
    task automatic cyc(input logic [5:0] o, input logic mr);
        op        = o;
        mem_ready = mr;
        @(posedge clk);
        #1;
    endtask

    task automatic run_path(input logic [5:0] o, input int n, input int exp_seq [4]);
        for (int i = 0; i < n; i++) begin
            cyc(o, 1'b1);
            chk("seq_state", {28'd0, state}, exp_seq[i]);
        end
    endtask

    initial begin
        reset     = 1'b1;
        op        = OpR;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_memread", {31'd0, MemRead}, 32'd0);
        chk("rst_alusrcb", {30'd0, ALUSrcB}, 32'd1);
        reset = 1'b0;

        // R-type: 0,1,6,7,0; mem_ready ignored in decode, op ignored in exec
        cyc(OpR, 1'b1);   chk("r_s1", {28'd0, state}, 32'd1);
        cyc(OpR, 1'b0);   chk("r_s6", {28'd0, state}, 32'd6);
        cyc(OpBad, 1'b0); chk("r_s7", {28'd0, state}, 32'd7);
        chk("r_regwrite", {31'd0, RegWrite}, 32'd1);
        chk("r_regdst", {31'd0, RegDst}, 32'd1);
        cyc(OpR, 1'b1);   chk("r_s0", {28'd0, state}, 32'd0);

        // lw with three wait cycles in memread
        cyc(OpLw, 1'b1);  chk("lw_s1", {28'd0, state}, 32'd1);
        cyc(OpLw, 1'b1);  chk("lw_s2", {28'd0, state}, 32'd2);
        cyc(OpLw, 1'b0);  chk("lw_s3", {28'd0, state}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            cyc(OpLw, 1'b0);
            chk("lw_hold", {28'd0, state}, 32'd3);
            chk("lw_memread", {30'd0, MemRead, IorD}, 32'd3);
        end
        cyc(OpLw, 1'b1);  chk("lw_s4", {28'd0, state}, 32'd4);
        chk("lw_wb", {30'd0, RegWrite, MemtoReg}, 32'd3);
        cyc(OpR, 1'b0);   chk("lw_s0", {28'd0, state}, 32'd0);

        // sw, beq, j
        run_path(OpSw, 4, '{1, 2, 5, 0});
        run_path(OpBeq, 3, '{1, 8, 0, 0});
        run_path(OpJ, 3, '{1, 9, 0, 0});
`ifdef MC_SEQ_PERF_EN
        chk("retired_5", retired, 32'd5);
`else
        chk("retired_0", retired, 32'd0);
`endif

        // Fetch stalls two cycles before memory answers
        for (int i = 0; i < 2; i++) begin
            op        = OpBad;
            mem_ready = 1'b0;
            #1;
            chk("stall_pcw_irw", {30'd0, PCWrite, IRWrite}, 32'd0);
            @(posedge clk);
            #1;
            chk("stall_state", {28'd0, state}, 32'd0);
        end
        mem_ready = 1'b1;
        #1;
        chk("fetch_pcw_irw", {30'd0, PCWrite, IRWrite}, 32'd3);
        @(posedge clk);
        #1;
        chk("fetch_s1", {28'd0, state}, 32'd1);

        // Illegal opcode traps until reset
        cyc(OpBad, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc(6'($urandom), 1'($urandom));
            chk("trap_state", {28'd0, state}, 32'd10);
            chk("trap_illegal", {31'd0, illegal}, 32'd1);
        end
        reset = 1'b1;
        #1;
        chk("trap_rst_state", {28'd0, state}, 32'd0);
        chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        chk("trap_rst_retired", retired, 32'd0);
        #2;
        op        = OpSw;
        mem_ready = 1'b1;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        chk("sw_s1", {28'd0, state}, 32'd1);
        cyc(OpSw, 1'b1);  chk("sw_s2", {28'd0, state}, 32'd2);
        cyc(OpSw, 1'b0);  chk("sw_s5", {28'd0, state}, 32'd5);

        // Async reset in memwrite aborts the store without a clock edge
        #1;
        chk("sw_memwrite", {31'd0, MemWrite}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("abort_state", {28'd0, state}, 32'd0);
        #4;
        op        = OpR;
        mem_ready = 1'b1;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_s1", {28'd0, state}, 32'd1);
        run_path(OpR, 3, '{6, 7, 0, 0});
`ifdef MC_SEQ_PERF_EN
        chk("retired_1", retired, 32'd1);
`else
        chk("retired_0b", retired, 32'd0);
`endif
        cyc(OpR, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: op  in  6  opcode from instruction register; mem_ready  in  1  memory completes current access this cycle.
REQ-003 SHALL have outputs, 1 bit each: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst.
REQ-004 SHALL have outputs, 2 bits each: PCSource, ALUOp, ALUSrcB.
REQ-005 SHALL have outputs: state  out  4  current state code; illegal  out  1  sticky trap flag; retired  out  32  instructions completed.

Function
REQ-006 SHALL hold a registered 4-bit state with codes S0 fetch=0, S1 decode=1, S2 memaddr=2, S3 memread=3, S4 lwwb=4, S5 memwrite=5, S6 exec=6, S7 rwb=7, S8 branch=8, S9 jump=9, S10 trap=10.
REQ-007 SHALL drive all control outputs combinationally from state and mem_ready only; unlisted outputs are 0 in each state.
REQ-008 S0: MemRead=1, ALUSrcB=01; IRWrite=PCWrite=mem_ready; stays in S0 while mem_ready=0, else goes to S1.
REQ-009 S1: ALUSrcB=11; next state by op: 000000->S6, 100011/101011->S2, 000100->S8, 000010->S9, any other->S10.
REQ-010 S2: ALUSrcA=1, ALUSrcB=10; op 100011->S3, 101011->S5.
REQ-011 S3: MemRead=1, IorD=1; holds until mem_ready=1, then goes to S4.
REQ-012 S4: RegWrite=1, MemtoReg=1, RegDst=0; goes to S0.
REQ-013 S5: MemWrite=1, IorD=1; holds until mem_ready=1, then goes to S0.
REQ-014 S6: ALUSrcA=1, ALUOp=10; goes to S7. S7: RegDst=1, RegWrite=1; goes to S0.
REQ-015 S8: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01; goes to S0. S9: PCWrite=1, PCSource=10; goes to S0.
REQ-016 S10: all write/read enables 0, illegal=1; remains in S10 until reset.
REQ-017 Any unused state code (11-15) SHALL transition to S10 on the next edge.
REQ-018 op SHALL be sampled only in S1 and S2; op changes in other states have no effect.
REQ-019 mem_ready SHALL be ignored outside S0, S3 and S5.
REQ-020 A memory access SHALL keep MemRead or MemWrite asserted continuously from state entry until the mem_ready cycle, inclusive.

Reset
REQ-021 reset=1 SHALL force state=S0, illegal=0 and retired=0 asynchronously.
REQ-022 While reset=1, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite and RegWrite SHALL be forced to 0; all other outputs take their S0 values.
REQ-023 Reset asserted mid-instruction SHALL abort the instruction with no pending write; the first fetch starts on the first edge after reset deasserts.

Configuration
REQ-024 With MC_SEQ_PERF_EN defined, retired SHALL increment by 1, wrapping modulo 2^32, on each edge leaving S4, S5 (when mem_ready=1), S7, S8 or S9.
REQ-025 Without MC_SEQ_PERF_EN, retired SHALL be constant 0, no counter flops exist, and the port is retained.

Verification
REQ-026 Reset, then op=000000 with mem_ready=1 -> state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in S7.
REQ-027 op=100011, mem_ready=0 for 3 cycles in S3 -> S3 held 4 cycles with MemRead=IorD=1; S4 asserts RegWrite=MemtoReg=1.
REQ-028 Fetch with mem_ready low for 2 cycles -> PCWrite=IRWrite=0 for those cycles, both 1 in the third cycle, then state=1.
REQ-029 op=111111 in S1 -> state=10, illegal=1, all enables 0 for 20 cycles; reset -> state=0, illegal=0.
REQ-030 Reset pulsed while in S5 -> MemWrite drops to 0 immediately, state=0 with no clock edge required.
REQ-031 With MC_SEQ_PERF_EN, run 5 instructions (R, lw, sw, beq, j) -> retired=5; without the macro, retired=0.
